datapath_control_fsm: RTL



---
 rtl/cpu_isa_pkg.sv | 71 +++++++
 rtl/datapath_control_fsm_cond_eval.sv | 31 +++
 rtl/datapath_control_fsm.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA encodings, condition codes, PSR bit positions and control FSM states.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package cpu_isa_pkg;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_SHIFT  = 4'b1000;
  localparam logic [3:0] OP_MEMJ   = 4'b0100;
  localparam logic [3:0] OP_BCOND  = 4'b1100;

  localparam logic [3:0] ALU_ADD   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b1001;
  localparam logic [3:0] ALU_AND   = 4'b0001;
  localparam logic [3:0] ALU_OR    = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_CMP   = 4'b1011;
  localparam logic [3:0] ALU_MOV   = 4'b1101;

  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [1:0] CR_SHIFT = 2'b00;
  localparam logic [1:0] CR_ALU   = 2'b01;
  localparam logic [1:0] CR_IMM   = 2'b10;
  localparam logic [1:0] CR_LINK  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EX_ALU   = 4'd2,
    S_EX_SHIFT = 4'd3,
    S_EX_LOAD  = 4'd4,
    S_WB_LOAD  = 4'd5,
    S_EX_STOR  = 4'd6,
    S_EX_BR    = 4'd7,
    S_EX_JMP   = 4'd8,
    S_EX_JAL   = 4'd9
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd10
`endif
  } state_t;

  function automatic logic is_alu_code(input logic [3:0] code);
    return code inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_CMP, ALU_MOV};
  endfunction

  function automatic logic is_flag_op(input logic [3:0] code);
    return code inside {ALU_ADD, ALU_SUB, ALU_CMP};
  endfunction

endpackage

// File: rtl/datapath_control_fsm_cond_eval.sv
// Combinational branch/jump condition evaluation against the PSR flags.
module cond_eval
  import cpu_isa_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [7:0] i_psr,
  output logic       o_taken
);

  logic w_unused_psr;
  assign w_unused_psr = &{1'b0, i_psr[4:3], i_psr[1]};

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken =  i_psr[PSR_Z];
      COND_NE: o_taken = ~i_psr[PSR_Z];
      COND_CS: o_taken =  i_psr[PSR_C];
      COND_CC: o_taken = ~i_psr[PSR_C];
      COND_HI: o_taken =  i_psr[PSR_L];
      COND_LS: o_taken = ~i_psr[PSR_L];
      COND_GT: o_taken =  i_psr[PSR_N];
      COND_LE: o_taken = ~i_psr[PSR_N];
      COND_FS: o_taken =  i_psr[PSR_F];
      COND_FC: o_taken = ~i_psr[PSR_F];
      COND_UC: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_control_fsm.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK control unit for the 16-bit datapath.
// Define CTRL_ILLEGAL_TRAP_EN to halt in TRAP on undefined encodings instead of executing a NOP.
module datapath_control_fsm
  import cpu_isa_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   memdata,
  input  logic [7:0]         PSROut,
  output logic               PCEN,
  output logic               PSREN,
  output logic               nextInstruction,
  output logic               updateAddress,
  output logic               StoreReg,
  output logic               WriteData,
  output logic               regWrite,
  output logic               ZeroExtend,
  output logic               PCinstruction,
  output logic               SrcB,
  output logic               shiftType,
  output logic               resultEn,
  output logic               jumpEN,
  output logic               BranchEN,
  output logic               jalEN,
  output logic               memWrite,
  output logic [WIDTH-1:0]   shiftDir,
  output logic [7:0]         shiftAmt,
  output logic [REGBITS-1:0] ALUcond,
  output logic [1:0]         chooseResult,
  output logic               halted
);

  state_t               r_state;
  logic [WIDTH-1:0]     r_ir;
  logic                 r_PCEN, r_PSREN, r_nextInstruction, r_updateAddress;
  logic                 r_StoreReg, r_WriteData, r_regWrite, r_ZeroExtend;
  logic                 r_PCinstruction, r_SrcB, r_shiftType, r_resultEn;
  logic                 r_jalEN, r_memWrite, r_is_br, r_is_jmp;
  logic [WIDTH-1:0]     r_shiftDir;
  logic [7:0]           r_shiftAmt;
  logic [REGBITS-1:0]   r_ALUcond;
  logic [1:0]           r_chooseResult;
  logic                 r_halted;

  logic [3:0] w_op, w_ext, w_cond;
  logic       w_taken;

  assign w_op   = r_ir[15:12];
  assign w_ext  = r_ir[7:4];
  assign w_cond = r_ir[11:8];

  cond_eval u_cond_eval (
    .i_cond  (w_cond),
    .i_psr   (PSROut),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_FETCH;
      r_ir              <= '0;
      r_PCEN            <= 1'b0;
      r_PSREN           <= 1'b0;
      r_nextInstruction <= 1'b0;
      r_updateAddress   <= 1'b0;
      r_StoreReg        <= 1'b0;
      r_WriteData       <= 1'b0;
      r_regWrite        <= 1'b0;
      r_ZeroExtend      <= 1'b0;
      r_PCinstruction   <= 1'b0;
      r_SrcB            <= 1'b0;
      r_shiftType       <= 1'b0;
      r_resultEn        <= 1'b0;
      r_jalEN           <= 1'b0;
      r_memWrite        <= 1'b0;
      r_is_br           <= 1'b0;
      r_is_jmp          <= 1'b0;
      r_shiftDir        <= '0;
      r_shiftAmt        <= '0;
      r_ALUcond         <= '0;
      r_chooseResult    <= CR_SHIFT;
      r_halted          <= 1'b0;
    end else begin
      // Outputs are registered for the state being entered; everything idles low by default.
      r_PCEN            <= 1'b0;
      r_PSREN           <= 1'b0;
      r_nextInstruction <= 1'b0;
      r_updateAddress   <= 1'b0;
      r_StoreReg        <= 1'b0;
      r_WriteData       <= 1'b0;
      r_regWrite        <= 1'b0;
      r_ZeroExtend      <= 1'b0;
      r_PCinstruction   <= 1'b0;
      r_SrcB            <= 1'b0;
      r_shiftType       <= 1'b0;
      r_resultEn        <= 1'b0;
      r_jalEN           <= 1'b0;
      r_memWrite        <= 1'b0;
      r_is_br           <= 1'b0;
      r_is_jmp          <= 1'b0;
      r_shiftDir        <= '0;
      r_shiftAmt        <= '0;
      r_ALUcond         <= '0;
      r_chooseResult    <= CR_SHIFT;
      r_halted          <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir    <= memdata;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_op == OP_RTYPE && is_alu_code(w_ext)) begin
            r_state         <= S_EX_ALU;
            r_ALUcond       <= REGBITS'(w_ext);
            r_SrcB          <= 1'b1;
            r_chooseResult  <= CR_ALU;
            r_resultEn      <= 1'b1;
            r_WriteData     <= 1'b1;
            r_regWrite      <= (w_ext != ALU_CMP);
            r_PSREN         <= is_flag_op(w_ext);
            r_PCEN          <= 1'b1;
            r_PCinstruction <= 1'b1;
          end else if (is_alu_code(w_op)) begin
            r_state         <= S_EX_ALU;
            r_ALUcond       <= REGBITS'(w_op);
            r_chooseResult  <= (w_op == ALU_MOV) ? CR_IMM : CR_ALU;
            r_ZeroExtend    <= (w_op inside {ALU_AND, ALU_OR, ALU_XOR});
            r_resultEn      <= 1'b1;
            r_WriteData     <= 1'b1;
            r_regWrite      <= (w_op != ALU_CMP);
            r_PSREN         <= is_flag_op(w_op);
            r_PCEN          <= 1'b1;
            r_PCinstruction <= 1'b1;
          end else if (w_op == OP_SHIFT && (w_ext == EXT_LSH || w_ext[3:1] == 3'b000)) begin
            r_state         <= S_EX_SHIFT;
            r_chooseResult  <= CR_SHIFT;
            r_regWrite      <= 1'b1;
            r_WriteData     <= 1'b1;
            r_PCEN          <= 1'b1;
            r_PCinstruction <= 1'b1;
            if (w_ext[3:1] == 3'b000) begin
              r_shiftType <= 1'b1;
              r_shiftAmt  <= {{3{r_ir[4]}}, r_ir[4:0]};
              r_shiftDir  <= {WIDTH{r_ir[4]}};
            end
          end else if (w_op == OP_MEMJ && w_ext == EXT_LOAD) begin
            r_state    <= S_EX_LOAD;
            r_StoreReg <= 1'b1;
          end else if (w_op == OP_MEMJ && w_ext == EXT_STOR) begin
            r_state         <= S_EX_STOR;
            r_StoreReg      <= 1'b1;
            r_memWrite      <= 1'b1;
            r_PCEN          <= 1'b1;
            r_PCinstruction <= 1'b1;
          end else if (w_op == OP_MEMJ && w_ext == EXT_JAL) begin
            r_state        <= S_EX_JAL;
            r_jalEN        <= 1'b1;
            r_chooseResult <= CR_LINK;
            r_regWrite     <= 1'b1;
            r_PCEN         <= 1'b1;
          end else if (w_op == OP_MEMJ && w_ext == EXT_JCOND) begin
            r_state  <= S_EX_JMP;
            r_is_jmp <= 1'b1;
            r_PCEN   <= 1'b1;
          end else if (w_op == OP_BCOND) begin
            r_state <= S_EX_BR;
            r_is_br <= 1'b1;
            r_PCEN  <= 1'b1;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_state  <= S_TRAP;
            r_halted <= 1'b1;
`else
            r_state         <= S_EX_ALU;
            r_PCEN          <= 1'b1;
            r_PCinstruction <= 1'b1;
`endif
          end
        end
        S_EX_LOAD: begin
          r_state         <= S_WB_LOAD;
          r_regWrite      <= 1'b1;
          r_PCEN          <= 1'b1;
          r_PCinstruction <= 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP: begin
          r_state  <= S_TRAP;
          r_halted <= 1'b1;
        end
`endif
        default: begin
          r_state           <= S_FETCH;
          r_nextInstruction <= 1'b1;
          r_updateAddress   <= 1'b1;
        end
      endcase
    end
  end

  // Branch/jump outcome follows the live PSR during the EX cycle.
  assign BranchEN        = r_is_br & w_taken;
  assign jumpEN          = r_is_jmp & w_taken;
  assign PCinstruction   = r_PCinstruction | ((r_is_br | r_is_jmp) & ~w_taken);
  assign PCEN            = r_PCEN;
  assign PSREN           = r_PSREN;
  assign nextInstruction = r_nextInstruction;
  assign updateAddress   = r_updateAddress;
  assign StoreReg        = r_StoreReg;
  assign WriteData       = r_WriteData;
  assign regWrite        = r_regWrite;
  assign ZeroExtend      = r_ZeroExtend;
  assign SrcB            = r_SrcB;
  assign shiftType       = r_shiftType;
  assign resultEn        = r_resultEn;
  assign jalEN           = r_jalEN;
  assign memWrite        = r_memWrite;
  assign shiftDir        = r_shiftDir;
  assign shiftAmt        = r_shiftAmt;
  assign ALUcond         = r_ALUcond;
  assign chooseResult    = r_chooseResult;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign halted          = r_halted;
`else
  assign halted          = 1'b0;
  logic w_unused_halt;
  assign w_unused_halt = r_halted;
`endif

endmodule
